// File: rtl/machine_mode_types_1_13_pkg.sv
// Shared types for the trap sequencer: exception/interrupt cause codes, exc_vec bit
// positions, FSM state encoding, privilege levels and xtvec mode constants.
package machine_mode_types_1_13_pkg;

  typedef enum logic [4:0] {
    ExcInsnMisaligned = 5'd0,
    ExcInsnFault      = 5'd1,
    ExcIllegalInsn    = 5'd2,
    ExcBreakpoint     = 5'd3,
    ExcLoadMisaligned = 5'd4,
    ExcLoadFault      = 5'd5,
    ExcStoreMisalign  = 5'd6,
    ExcStoreFault     = 5'd7,
    ExcEcallU         = 5'd8,
    ExcEcallS         = 5'd9,
    ExcEcallM         = 5'd11,
    ExcInsnPage       = 5'd12,
    ExcLoadPage       = 5'd13,
    ExcStorePage      = 5'd15,
    ExcRmgmt          = 5'd24
  } ex_code_t;

  typedef enum logic [4:0] {
    IntSoft  = 5'd3,
    IntTimer = 5'd7,
    IntExt   = 5'd11
  } int_code_t;

  typedef enum logic [1:0] {
    StIdle,
    StCommit,
    StRedirect,
    StWfi
  } trap_state_t;

  typedef enum logic [1:0] {
    PrivU = 2'd0,
    PrivS = 2'd1,
    PrivM = 2'd3
  } priv_level_t;

  localparam logic [1:0] MtvecDirect   = 2'd0;
  localparam logic [1:0] MtvecVectored = 2'd1;

  // Bit positions inside exc_vec.
  localparam int unsigned ExBitRmgmt     = 0;
  localparam int unsigned ExBitFaultInsn = 1;
  localparam int unsigned ExBitMalInsn   = 2;
  localparam int unsigned ExBitIllegal   = 3;
  localparam int unsigned ExBitFaultL    = 4;
  localparam int unsigned ExBitMalL      = 5;
  localparam int unsigned ExBitFaultS    = 6;
  localparam int unsigned ExBitMalS      = 7;
  localparam int unsigned ExBitBreak     = 8;
  localparam int unsigned ExBitEnv       = 9;
  localparam int unsigned ExBitInsnPage  = 10;
  localparam int unsigned ExBitLoadPage  = 11;
  localparam int unsigned ExBitStorePage = 12;

endpackage

// File: rtl/prv_trap_prio_enc.sv
// Combinational trap priority encoder.
//   exc_vec   in  13  exception request lines
//   ext_int, soft_int, timer_int  in  interrupt pending lines
//   curr_priv in  2   current privilege (selects the env-call code)
//   valid     out     some exception or interrupt is pending
//   intr      out     winner is an interrupt
//   code      out 5   cause code of the winner
//   tval_sel  out     1: tval is badaddr, 0: tval is zero
// Interrupt enable is not applied here; the caller gates interrupts with gie.
module prv_trap_prio_enc
  import machine_mode_types_1_13_pkg::*;
(
  input  logic [12:0] exc_vec,
  input  logic        ext_int,
  input  logic        soft_int,
  input  logic        timer_int,
  input  logic [1:0]  curr_priv,
  output logic        valid,
  output logic        intr,
  output logic [4:0]  code,
  output logic        tval_sel
);

  logic [4:0] env_code;

  always_comb begin
    case (curr_priv)
      PrivU:   env_code = ExcEcallU;
      PrivS:   env_code = ExcEcallS;
      default: env_code = ExcEcallM;
    endcase
  end

  always_comb begin
    valid    = 1'b1;
    intr     = 1'b0;
    code     = 5'd0;
    tval_sel = 1'b0;
    if (exc_vec[ExBitBreak]) begin
      code = ExcBreakpoint;
    end else if (exc_vec[ExBitInsnPage]) begin
      code = ExcInsnPage; tval_sel = 1'b1;
    end else if (exc_vec[ExBitFaultInsn]) begin
      code = ExcInsnFault; tval_sel = 1'b1;
    end else if (exc_vec[ExBitIllegal]) begin
      code = ExcIllegalInsn; tval_sel = 1'b1;
    end else if (exc_vec[ExBitMalInsn]) begin
      code = ExcInsnMisaligned; tval_sel = 1'b1;
    end else if (exc_vec[ExBitEnv]) begin
      code = env_code;
    end else if (exc_vec[ExBitMalS]) begin
      code = ExcStoreMisalign; tval_sel = 1'b1;
    end else if (exc_vec[ExBitMalL]) begin
      code = ExcLoadMisaligned; tval_sel = 1'b1;
    end else if (exc_vec[ExBitStorePage]) begin
      code = ExcStorePage; tval_sel = 1'b1;
    end else if (exc_vec[ExBitLoadPage]) begin
      code = ExcLoadPage; tval_sel = 1'b1;
    end else if (exc_vec[ExBitFaultS]) begin
      code = ExcStoreFault; tval_sel = 1'b1;
    end else if (exc_vec[ExBitFaultL]) begin
      code = ExcLoadFault; tval_sel = 1'b1;
    end else if (exc_vec[ExBitRmgmt]) begin
      code = ExcRmgmt;
    end else if (ext_int) begin
      intr = 1'b1; code = IntExt;
    end else if (soft_int) begin
      intr = 1'b1; code = IntSoft;
    end else if (timer_int) begin
      intr = 1'b1; code = IntTimer;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/prv_trap_sequencer.sv
// Trap entry / xRET sequencer and WFI stall owner.
//   CLK, RST              clock, synchronous active-high reset
//   exc_vec, epc, badaddr exception requests and their context
//   mret, sret, wfi       retiring special instructions
//   pipe_clear            pipeline flush acknowledge for insert_pc
//   ext/soft/timer_int    pending interrupt lines, gie global enable
//   curr_priv, mtvec, mepc_r, sepc_r  CSR state
//   priv_pc, insert_pc, intr          redirect request to hazard
//   trap_we, ret_we                   CSR update strobes
//   mcause_o, mepc_o, mtval_o         captured trap information
//   wfi_stall                         fetch hold while in WFI
module prv_trap_sequencer
  import machine_mode_types_1_13_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          MODE_VEC = 1'b1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [12:0]     exc_vec,
  input  logic [XLEN-1:0] epc,
  input  logic [XLEN-1:0] badaddr,
  input  logic            mret,
  input  logic            sret,
  input  logic            wfi,
  input  logic            pipe_clear,
  input  logic            ext_int,
  input  logic            soft_int,
  input  logic            timer_int,
  input  logic            gie,
  input  logic [1:0]      curr_priv,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc_r,
  input  logic [XLEN-1:0] sepc_r,
  output logic [XLEN-1:0] priv_pc,
  output logic            insert_pc,
  output logic            intr,
  output logic            trap_we,
  output logic            ret_we,
  output logic [XLEN-1:0] mcause_o,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mtval_o,
  output logic            wfi_stall
);

  trap_state_t     state_q;
  logic [XLEN-1:0] priv_pc_q, mcause_q, mepc_q, mtval_q;
  logic            insert_pc_q, intr_q, trap_we_q, wfi_stall_q;

  logic            enc_valid, enc_intr, enc_tval_sel;
  logic [4:0]      enc_code;
  logic            int_pend, take_trap;
  logic [XLEN-1:0] tvec_base, trap_target;

  prv_trap_prio_enc u_prio_enc (
    .exc_vec   (exc_vec),
    .ext_int   (ext_int),
    .soft_int  (soft_int),
    .timer_int (timer_int),
    .curr_priv (curr_priv),
    .valid     (enc_valid),
    .intr      (enc_intr),
    .code      (enc_code),
    .tval_sel  (enc_tval_sel)
  );

  assign int_pend  = ext_int | soft_int | timer_int;
  // Exceptions are never masked; interrupts need gie.
  assign take_trap = enc_valid & (~enc_intr | gie);

  // Vector offset applies only to interrupts in vectored mode; modes 2/3 fall back to direct.
  always_comb begin
    tvec_base   = {mtvec[XLEN-1:2], 2'b00};
    trap_target = tvec_base;
    if (MODE_VEC && enc_intr && (mtvec[1:0] == MtvecVectored)) begin
      trap_target = tvec_base + {{(XLEN-7){1'b0}}, enc_code, 2'b00};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      priv_pc_q   <= '0;
      mcause_q    <= '0;
      mepc_q      <= '0;
      mtval_q     <= '0;
      insert_pc_q <= 1'b0;
      intr_q      <= 1'b0;
      trap_we_q   <= 1'b0;
      wfi_stall_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (take_trap) begin
            state_q   <= StCommit;
            trap_we_q <= 1'b1;
            intr_q    <= enc_intr;
            mcause_q  <= {enc_intr, {(XLEN-6){1'b0}}, enc_code};
            mepc_q    <= epc;
            mtval_q   <= enc_tval_sel ? badaddr : '0;
            // Target is latched with the cause so a later mtvec change cannot tear it.
            priv_pc_q <= trap_target;
          end else if (mret || sret) begin
            state_q     <= StRedirect;
            insert_pc_q <= 1'b1;
            intr_q      <= 1'b0;
            priv_pc_q   <= mret ? mepc_r : sepc_r;
          end else if (wfi && !int_pend) begin
            state_q     <= StWfi;
            wfi_stall_q <= 1'b1;
          end
        end
        StCommit: begin
          state_q     <= StRedirect;
          trap_we_q   <= 1'b0;
          insert_pc_q <= 1'b1;
        end
        StRedirect: begin
          if (pipe_clear) begin
            state_q     <= StIdle;
            insert_pc_q <= 1'b0;
          end
        end
        StWfi: begin
          // Wake on any pending line; IDLE decides whether it is actually taken.
          if (int_pend) begin
            state_q     <= StIdle;
            wfi_stall_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign priv_pc   = priv_pc_q;
  assign insert_pc = insert_pc_q;
  assign intr      = intr_q;
  // Masked by RST so a trap being reset out of COMMIT never reaches the CSR file.
  assign trap_we   = trap_we_q & ~RST;
  assign ret_we    = ~RST & (state_q == StIdle) & ~take_trap & (mret | sret);
  assign mcause_o  = mcause_q;
  assign mepc_o    = mepc_q;
  assign mtval_o   = mtval_q;
  assign wfi_stall = wfi_stall_q;

endmodule

// File: tb/tb_prv_trap_sequencer.sv
module tb_prv_trap_sequencer;

  logic        CLK, RST;
  logic [12:0] exc_vec;
  logic [31:0] epc, badaddr, mtvec, mepc_r, sepc_r;
  logic        mret, sret, wfi, pipe_clear, ext_int, soft_int, timer_int, gie;
  logic [1:0]  curr_priv;
  logic [31:0] priv_pc, mcause_o, mepc_o, mtval_o;
  logic        insert_pc, intr, trap_we, ret_we, wfi_stall;

  int n_tests = 0;
  int n_fail  = 0;

  prv_trap_sequencer #(.XLEN(32), .MODE_VEC(1'b1)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .exc_vec    (exc_vec),
    .epc        (epc),
    .badaddr    (badaddr),
    .mret       (mret),
    .sret       (sret),
    .wfi        (wfi),
    .pipe_clear (pipe_clear),
    .ext_int    (ext_int),
    .soft_int   (soft_int),
    .timer_int  (timer_int),
    .gie        (gie),
    .curr_priv  (curr_priv),
    .mtvec      (mtvec),
    .mepc_r     (mepc_r),
    .sepc_r     (sepc_r),
    .priv_pc    (priv_pc),
    .insert_pc  (insert_pc),
    .intr       (intr),
    .trap_we    (trap_we),
    .ret_we     (ret_we),
    .mcause_o   (mcause_o),
    .mepc_o     (mepc_o),
    .mtval_o    (mtval_o),
    .wfi_stall  (wfi_stall)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Exception at cycle N: trap_we in N+1, insert_pc from N+2, then acked.
  task automatic run_exc(input string tag, input logic [12:0] vec, input logic [1:0] priv,
                         input logic [31:0] pc, input logic [31:0] bad,
                         input logic [31:0] exp_cause, input logic [31:0] exp_tval,
                         input logic [31:0] exp_pc);
    exc_vec = vec; curr_priv = priv; epc = pc; badaddr = bad;
    #1 check_eq({tag, "_we_n"}, trap_we, 0);
    tick(); exc_vec = '0;
    #1;
    check_eq({tag, "_we"}, trap_we, 1);
    check_eq({tag, "_cause"}, mcause_o, exp_cause);
    check_eq({tag, "_epc"}, mepc_o, pc);
    check_eq({tag, "_tval"}, mtval_o, exp_tval);
    check_eq({tag, "_ins_n1"}, insert_pc, 0);
    tick();
    check_eq({tag, "_ins"}, insert_pc, 1);
    check_eq({tag, "_pc"}, priv_pc, exp_pc);
    check_eq({tag, "_intr"}, intr, 0);
    check_eq({tag, "_we_off"}, trap_we, 0);
    pipe_clear = 1'b1;
    tick(); pipe_clear = 1'b0;
    check_eq({tag, "_ins_clr"}, insert_pc, 0);
  endtask

  task automatic run_int(input string tag, input logic [2:0] ints, input logic [31:0] tvec,
                         input logic [31:0] exp_cause, input logic [31:0] exp_pc);
    {ext_int, soft_int, timer_int} = ints; gie = 1'b1; mtvec = tvec; epc = 32'h0000_0300;
    badaddr = 32'h5555_AAAA;
    tick(); {ext_int, soft_int, timer_int} = 3'b000;
    #1;
    check_eq({tag, "_we"}, trap_we, 1);
    check_eq({tag, "_cause"}, mcause_o, exp_cause);
    check_eq({tag, "_epc"}, mepc_o, 32'h0000_0300);
    check_eq({tag, "_tval"}, mtval_o, 0);
    tick();
    check_eq({tag, "_ins"}, insert_pc, 1);
    check_eq({tag, "_pc"}, priv_pc, exp_pc);
    check_eq({tag, "_intr"}, intr, 1);
    pipe_clear = 1'b1;
    tick(); pipe_clear = 1'b0;
  endtask

  initial begin
    RST = 1'b1; exc_vec = '0; epc = '0; badaddr = '0; mtvec = 32'h8000_0000;
    mepc_r = '0; sepc_r = '0; mret = 0; sret = 0; wfi = 0; pipe_clear = 0;
    ext_int = 0; soft_int = 0; timer_int = 0; gie = 0; curr_priv = 2'd3;
    tick(); tick();
    RST = 1'b0;
    check_eq("rst_ins", insert_pc, 0);
    check_eq("rst_pc", priv_pc, 0);
    check_eq("rst_cause", mcause_o, 0);
    check_eq("rst_stall", wfi_stall, 0);
    check_eq("rst_we", trap_we, 0);

    // 1: illegal instruction, direct mode.
    run_exc("illegal", 13'h008, 2'd3, 32'h200, 32'h0000_FFFF, 32'd2, 32'h0000_FFFF,
            32'h8000_0000);

    // 2: external interrupt, vectored.
    run_int("ext_vec", 3'b100, 32'h8000_0001, 32'h8000_000B, 32'h8000_002C);
    // Vectored offset wraps past 2^32; mode 3 acts as direct.
    run_int("wrap", 3'b100, 32'hFFFF_FFFD, 32'h8000_000B, 32'h0000_0028);
    run_int("mode3", 3'b010, 32'h8000_0003, 32'h8000_0003, 32'h8000_0000);

    // 3: breakpoint + fault_l + timer: breakpoint wins, timer follows.
    mtvec = 32'h8000_0001; gie = 1'b1; timer_int = 1'b1;
    run_exc("bkpt", 13'h110, 2'd3, 32'h400, 32'hDEAD_BEEF, 32'd3, 32'd0, 32'h8000_0000);
    tick(); timer_int = 1'b0;
    #1;
    check_eq("tmr_we", trap_we, 1);
    check_eq("tmr_cause", mcause_o, 32'h8000_0007);
    tick();
    check_eq("tmr_pc", priv_pc, 32'h8000_001C);
    check_eq("tmr_intr", intr, 1);
    pipe_clear = 1'b1; tick(); pipe_clear = 1'b0;
    gie = 1'b0;

    // 4: env by privilege, plus a few priority pairs.
    run_exc("envU", 13'h200, 2'd0, 32'h500, 32'h1111, 32'd8, 32'd0, 32'h8000_0000);
    run_exc("envM", 13'h200, 2'd3, 32'h504, 32'h1111, 32'd11, 32'd0, 32'h8000_0000);
    run_exc("ipage", 13'h402, 2'd3, 32'h508, 32'h2222, 32'd12, 32'h2222, 32'h8000_0000);
    run_exc("spage", 13'h1010, 2'd3, 32'h50C, 32'h3333, 32'd15, 32'h3333, 32'h8000_0000);
    run_exc("rmgmt", 13'h001, 2'd3, 32'h510, 32'h4444, 32'd24, 32'd0, 32'h8000_0000);

    // 5: mret with delayed ack.
    mret = 1'b1; mepc_r = 32'h0000_1234;
    #1 check_eq("mret_we", ret_we, 1);
    tick(); mret = 1'b0;
    #1;
    check_eq("mret_we_off", ret_we, 0);
    check_eq("mret_ins", insert_pc, 1);
    check_eq("mret_pc", priv_pc, 32'h0000_1234);
    check_eq("mret_intr", intr, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("mret_hold", insert_pc, 1);
    end
    pipe_clear = 1'b1; tick(); pipe_clear = 1'b0;
    check_eq("mret_clr", insert_pc, 0);
    sret = 1'b1; sepc_r = 32'h0000_5678;
    #1 check_eq("sret_we", ret_we, 1);
    tick(); sret = 1'b0;
    check_eq("sret_pc", priv_pc, 32'h0000_5678);
    pipe_clear = 1'b1; tick(); pipe_clear = 1'b0;

    // 6: WFI, then wake with gie=0 (no trap).
    wfi = 1'b1;
    tick(); wfi = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_eq("wfi_stall", wfi_stall, 1);
      tick();
    end
    soft_int = 1'b1; gie = 1'b0;
    tick();
    check_eq("wfi_wake", wfi_stall, 0);
    tick();
    check_eq("wfi_no_trap", trap_we, 0);
    check_eq("wfi_no_ins", insert_pc, 0);
    soft_int = 1'b0;
    tick();

    // Reset during COMMIT discards the trap.
    exc_vec = 13'h008; epc = 32'h600; badaddr = 32'h7777;
    tick(); exc_vec = '0; RST = 1'b1;
    #1 check_eq("rst_commit_we", trap_we, 0);
    tick(); RST = 1'b0;
    check_eq("rstc_we", trap_we, 0);
    check_eq("rstc_ins", insert_pc, 0);
    check_eq("rstc_cause", mcause_o, 0);
    check_eq("rstc_epc", mepc_o, 0);
    check_eq("rstc_tval", mtval_o, 0);
    check_eq("rstc_pc", priv_pc, 0);
    tick();
    check_eq("rstc_ins2", insert_pc, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
